axil_cfg_master: RTL and testbench
==================================

// Module: axil_cfg_master
// PURPOSE
// - Single-outstanding AXI-Lite initiator: turns a valid/ready command stream (write or read of one 32-bit register) into AXI-Lite transactions.
// - Returns one response per command.
// - Drives the config slave of df_controller and SAURIA/DMA register files from a host-side sequencer or test harness.
// PARAMETERS
// - ADDR_W  32  AXI-Lite address width; data width fixed at 32, strobe at 4.
// - CNT_W   16  Width of the completed-transaction counter.
// PORTS
// - clk          in   1       clock
// - rst          in   1       synchronous reset, active-high
// - cmd_valid    in   1       command request
// - cmd_ready    out  1       command accepted when cmd_valid & cmd_ready
// - cmd_write    in   1       1 = write, 0 = read
// - cmd_addr     in   ADDR_W  register byte address
// - cmd_wdata    in   32      write data (ignored for reads)
// - cmd_wstrb    in   4       write byte strobes (ignored for reads)
// - rsp_valid    out  1       response available
// - rsp_ready    in   1       response consumed when rsp_valid & rsp_ready
// - rsp_write    out  1       response belongs to a write
// - rsp_rdata    out  32      read data; 0 for writes
// - rsp_resp     out  2       bresp/rresp as returned by the slave
// - err_sticky   out  1       set by any non-OKAY resp; cleared by err_clr
// - err_clr      in   1       clears err_sticky
// - txn_count    out  CNT_W   completed transactions; wraps modulo 2^CNT_W
// - m_awaddr/awvalid/awready, m_wdata/wstrb/wvalid/wready, m_bresp/bvalid/bready,
// - m_araddr/arvalid/arready, m_rdata/rresp/rvalid/rready
//   AXI-Lite master channels; addr ADDR_W, data 32, strb 4, resp 2
// BEHAVIOUR
// - Reset values: all outputs 0, including cmd_ready, every valid/ready, err_sticky, txn_count; FSM in IDLE.
//   cmd_ready = (state==IDLE) & !rst.
// - FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
// - IDLE: on cmd accept, latch addr/data/strb/write.
//   - Write goes to WR_REQ with awvalid=wvalid=1 the next cycle.
//   - Read goes to RD_REQ with arvalid=1 the next cycle.
// - WR_REQ:
//   - AW and W are independent. Each valid stays high with stable payload until its own handshake, then drops the cycle after.
//   - Both handshakes may occur in the same or different cycles, in either order.
//   - Leave for WR_RESP once both are done.
// - WR_RESP: bready=1. On bvalid, capture bresp, set rsp_rdata=0, go to RSP.
// - RD_REQ: arvalid held with stable araddr until arready, then go to RD_RESP.
// - RD_RESP: rready=1. On rvalid, capture rdata/rresp, go to RSP.
// - bready/rready are asserted only in their resp states, never early. A bvalid/rvalid arriving before the address handshake is left pending.
// - RSP:
//   - rsp_valid=1 with stable payload until rsp_ready.
//   - On handshake: txn_count += 1, then IDLE.
//   - cmd_ready rises the cycle after the rsp handshake (no same-cycle bypass).
// - Minimum latency, zero-wait slave:
//   - Write: cmd accept T0 -> aw/w valid T1 -> bready T2 -> bvalid at T2 -> rsp_valid T3.
//   - Read: same timing through the AR/R channels.
// - All AXI outputs are registered. Only cmd_ready is combinational, and only from state and rst.
// - err_sticky:
//   - Set in the cycle resp is captured if resp != 2'b00.
//   - If err_clr and a new error arrive in the same cycle, set wins.
// - txn_count wraps from 2^CNT_W-1 to 0 with no flag.
// - No timeout: a slave that never responds stalls the FSM. This is intended; the watchdog lives upstream.
// - Reset mid-transaction: FSM returns to IDLE and all valids drop on the next edge. The in-flight command is dropped and gets no response.
//   rst must be shared with the slave so the bus is left consistent.
// TESTING
// - Write 0x10 <- 0xDEADBEEF, wstrb 0xF, zero-wait slave -> aw/w at T1, rsp_valid at T3, rsp_resp=0, txn_count=1.
// - Write, awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 4 cycles with stable addr, single rsp.
// - Read 0x0, slave returns 0xC0000002 after 5-cycle rvalid delay -> rsp_rdata=0xC0000002, rsp_write=0, rready high only in RD_RESP.
// - Write with bresp=2'b10 -> rsp_resp=2'b10, err_sticky=1. err_clr pulse -> 0. Error and err_clr in the same cycle -> stays 1.
// - rsp_ready low 4 cycles -> rsp payload stable, cmd_ready low; accept on release, cmd_ready high the next cycle.
// - rst asserted during WR_REQ -> awvalid/wvalid 0 next cycle, no rsp, txn_count=0.
//   Run 2^CNT_W transactions with CNT_W=4 -> wraps to 0.

Source files
------------

// File: rtl/axil_cfg_master_if.sv
// AXI-Lite bus bundle between the config initiator and a register-file slave.
// Latency: wires only, no storage.
// Backpressure: carried by the per-channel valid/ready pairs.
interface axil_cfg_master_if #(
  parameter int ADDR_W = 32
);
  // write address channel
  logic [ADDR_W-1:0] m_awaddr;
  logic              m_awvalid;
  logic              m_awready;
  // write data channel
  logic [31:0]       m_wdata;
  logic [3:0]        m_wstrb;
  logic              m_wvalid;
  logic              m_wready;
  // write response channel
  logic [1:0]        m_bresp;
  logic              m_bvalid;
  logic              m_bready;
  // read address channel
  logic [ADDR_W-1:0] m_araddr;
  logic              m_arvalid;
  logic              m_arready;
  // read data channel
  logic [31:0]       m_rdata;
  logic [1:0]        m_rresp;
  logic              m_rvalid;
  logic              m_rready;

  modport master (
    output m_awaddr, m_awvalid, input m_awready,
    output m_wdata, m_wstrb, m_wvalid, input m_wready,
    input  m_bresp, m_bvalid, output m_bready,
    output m_araddr, m_arvalid, input m_arready,
    input  m_rdata, m_rresp, m_rvalid, output m_rready
  );

  modport slave (
    input  m_awaddr, m_awvalid, output m_awready,
    input  m_wdata, m_wstrb, m_wvalid, output m_wready,
    output m_bresp, m_bvalid, input m_bready,
    input  m_araddr, m_arvalid, output m_arready,
    output m_rdata, m_rresp, m_rvalid, input m_rready
  );
endinterface

// File: rtl/axil_cfg_master.sv
// Single-outstanding AXI-Lite initiator: one cmd in -> one AXI-Lite read/write -> one rsp out.
// Latency: cmd accept T0, AW/W or AR valid T1, B/R ready T2, rsp_valid T3 with a zero-wait slave.
// Backpressure: cmd_ready only in IDLE; rsp held until rsp_ready; a silent slave stalls forever.
module axil_cfg_master #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  // command stream
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  input  logic [3:0]        cmd_wstrb,
  // response stream
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_resp,
  // status
  output logic              err_sticky,
  input  logic              err_clr,
  output logic [CNT_W-1:0]  txn_count,
  // AXI-Lite master port
  axil_cfg_master_if.master axi
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t state;
  state_t state_nxt;

  logic cmd_acc;
  logic b_cap;
  logic r_cap;
  logic rsp_hs;
  logic err_set;

  // Ready depends only on state and reset so the upstream sequencer never sees a comb loop.
  assign cmd_ready = (state == IDLE) & ~rst;
  assign cmd_acc   = cmd_valid & cmd_ready;
  assign b_cap     = (state == WR_RESP) & axi.m_bvalid;
  assign r_cap     = (state == RD_RESP) & axi.m_rvalid;
  assign rsp_hs    = rsp_valid & rsp_ready;
  assign err_set   = (b_cap & (axi.m_bresp != 2'b00)) | (r_cap & (axi.m_rresp != 2'b00));

  // State register; reset drops any in-flight command without a response.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; AW and W are tracked by their own valids, so either order completes WR_REQ.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_acc) state_nxt = cmd_write ? WR_REQ : RD_REQ;
      WR_REQ:  if ((~axi.m_awvalid | axi.m_awready) & (~axi.m_wvalid | axi.m_wready))
                 state_nxt = WR_RESP;
      WR_RESP: if (axi.m_bvalid) state_nxt = RSP;
      RD_REQ:  if (axi.m_arready) state_nxt = RD_RESP;
      RD_RESP: if (axi.m_rvalid) state_nxt = RSP;
      RSP:     if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered AXI and response outputs, derived from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      axi.m_awaddr  <= '0;
      axi.m_awvalid <= 1'b0;
      axi.m_wdata   <= '0;
      axi.m_wstrb   <= '0;
      axi.m_wvalid  <= 1'b0;
      axi.m_bready  <= 1'b0;
      axi.m_araddr  <= '0;
      axi.m_arvalid <= 1'b0;
      axi.m_rready  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_write     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= '0;
    end else begin
      // payload is latched once at accept and held stable until the matching handshake
      if (cmd_acc) begin
        axi.m_awaddr <= cmd_addr;
        axi.m_araddr <= cmd_addr;
        axi.m_wdata  <= cmd_wdata;
        axi.m_wstrb  <= cmd_wstrb;
        rsp_write    <= cmd_write;
      end
      // each write-request valid drops independently after its own handshake
      if (cmd_acc & cmd_write)                    axi.m_awvalid <= 1'b1;
      else if (axi.m_awvalid & axi.m_awready)     axi.m_awvalid <= 1'b0;
      if (cmd_acc & cmd_write)                    axi.m_wvalid  <= 1'b1;
      else if (axi.m_wvalid & axi.m_wready)       axi.m_wvalid  <= 1'b0;
      axi.m_arvalid <= (state_nxt == RD_REQ);
      // response readies only in their own states, so early B/R stay pending on the bus
      axi.m_bready  <= (state_nxt == WR_RESP);
      axi.m_rready  <= (state_nxt == RD_RESP);
      rsp_valid     <= (state_nxt == RSP);
      if (b_cap) begin
        rsp_rdata <= 32'h0;
        rsp_resp  <= axi.m_bresp;
      end else if (r_cap) begin
        rsp_rdata <= axi.m_rdata;
        rsp_resp  <= axi.m_rresp;
      end
    end
  end

  // Sticky error flag; a new error in the same cycle as err_clr keeps it set.
  always_ff @(posedge clk) begin
    if (rst)          err_sticky <= 1'b0;
    else if (err_set) err_sticky <= 1'b1;
    else if (err_clr) err_sticky <= 1'b0;
  end

  // Completed-transaction counter, free-running wrap.
  always_ff @(posedge clk) begin
    if (rst)         txn_count <= '0;
    else if (rsp_hs) txn_count <= txn_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_axil_cfg_master.sv
// Directed bench for axil_cfg_master with a hand-driven AXI-Lite slave.
// Inputs are driven and outputs sampled on the falling edge.
// Counter width is 4 so the wrap can be reached in a short run.
module tb_axil_cfg_master;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [31:0]       cmd_wdata;
  logic [3:0]        cmd_wstrb;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_write;
  logic [31:0]       rsp_rdata;
  logic [1:0]        rsp_resp;
  logic              err_sticky;
  logic              err_clr;
  logic [CNT_W-1:0]  txn_count;

  int n_cmp;
  int n_err;

  axil_cfg_master_if #(.ADDR_W(ADDR_W)) bus ();

  axil_cfg_master #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_wstrb  (cmd_wstrb),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_write  (rsp_write),
    .rsp_rdata  (rsp_rdata),
    .rsp_resp   (rsp_resp),
    .err_sticky (err_sticky),
    .err_clr    (err_clr),
    .txn_count  (txn_count),
    .axi        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic slave_idle();
    bus.m_awready = 1'b0;
    bus.m_wready  = 1'b0;
    bus.m_bvalid  = 1'b0;
    bus.m_bresp   = 2'b00;
    bus.m_arready = 1'b0;
    bus.m_rvalid  = 1'b0;
    bus.m_rdata   = 32'h0;
    bus.m_rresp   = 2'b00;
  endtask

  // Presents one command and returns on the falling edge after the accepting edge (T1).
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int t;
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
    t = 0;
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    if (!cmd_ready) begin
      n_cmp++; n_err++;
      $display("FAIL issue_timeout: cmd_ready=%b required 1 within 50 cycles", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({cmd_ready, bus.m_awvalid, bus.m_wvalid, bus.m_arvalid, bus.m_bready, bus.m_rready, rsp_valid, err_sticky} !== 8'h00) begin
      n_err++; $display("FAIL reset_outputs: got %b required 00000000",
        {cmd_ready, bus.m_awvalid, bus.m_wvalid, bus.m_arvalid, bus.m_bready, bus.m_rready, rsp_valid, err_sticky});
    end
    n_cmp++;
    if ({txn_count, rsp_rdata, rsp_resp} !== {4'd0, 32'h0, 2'b00}) begin
      n_err++; $display("FAIL reset_payload: txn=%h rdata=%h resp=%b required 0/0/0", txn_count, rsp_rdata, rsp_resp);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %b required 1", cmd_ready); end
  endtask

  task automatic test_write_zero_wait();
    bus.m_awready = 1'b1; bus.m_wready = 1'b1; bus.m_bvalid = 1'b1; bus.m_bresp = 2'b00;
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    n_cmp++;
    if ({bus.m_awvalid, bus.m_wvalid, bus.m_bready, cmd_ready} !== 4'b1100) begin
      n_err++; $display("FAIL wr0_t1_valids: aw,w,b,cmdrdy=%b required 1100", {bus.m_awvalid, bus.m_wvalid, bus.m_bready, cmd_ready});
    end
    n_cmp++;
    if ({bus.m_awaddr, bus.m_wdata, bus.m_wstrb} !== {32'h10, 32'hDEADBEEF, 4'hF}) begin
      n_err++; $display("FAIL wr0_t1_payload: addr=%h data=%h strb=%h required 10/deadbeef/f", bus.m_awaddr, bus.m_wdata, bus.m_wstrb);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.m_awvalid, bus.m_wvalid, bus.m_bready, rsp_valid} !== 4'b0010) begin
      n_err++; $display("FAIL wr0_t2: aw,w,b,rsp=%b required 0010", {bus.m_awvalid, bus.m_wvalid, bus.m_bready, rsp_valid});
    end
    @(negedge clk);
    bus.m_bvalid = 1'b0;
    n_cmp++;
    if ({rsp_valid, rsp_write, rsp_resp, bus.m_bready, rsp_rdata} !== {1'b1, 1'b1, 2'b00, 1'b0, 32'h0}) begin
      n_err++; $display("FAIL wr0_t3_rsp: v=%b w=%b resp=%b bready=%b rdata=%h required 1/1/00/0/0",
        rsp_valid, rsp_write, rsp_resp, bus.m_bready, rsp_rdata);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_cmp++;
    if ({rsp_valid, cmd_ready, txn_count} !== {1'b0, 1'b1, 4'd1}) begin
      n_err++; $display("FAIL wr0_done: rsp_v=%b cmd_rdy=%b txn=%0d required 0/1/1", rsp_valid, cmd_ready, txn_count);
    end
    slave_idle();
  endtask

  task automatic test_aw_delay();
    logic [3:0] aw_seen;
    logic [3:0] w_seen;
    logic       addr_ok;
    bus.m_awready = 1'b0; bus.m_wready = 1'b1;
    issue(1'b1, 32'h24, 32'h12345678, 4'h3);
    addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      aw_seen[i] = bus.m_awvalid;
      w_seen[i]  = bus.m_wvalid;
      if (bus.m_awaddr !== 32'h24) addr_ok = 1'b0;
      if (i == 3) bus.m_awready = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if (aw_seen !== 4'b1111) begin n_err++; $display("FAIL awdly_awvalid: per-cycle %b required 1111", aw_seen); end
    n_cmp++;
    if (w_seen !== 4'b0001) begin n_err++; $display("FAIL awdly_wvalid: per-cycle %b required 0001", w_seen); end
    n_cmp++;
    if (addr_ok !== 1'b1) begin n_err++; $display("FAIL awdly_addr_stable: got %b required 1", addr_ok); end
    n_cmp++;
    if ({bus.m_awvalid, bus.m_bready} !== 2'b01) begin
      n_err++; $display("FAIL awdly_to_resp: aw,b=%b required 01", {bus.m_awvalid, bus.m_bready});
    end
    bus.m_awready = 1'b0; bus.m_bvalid = 1'b1;
    @(negedge clk);
    bus.m_bvalid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({rsp_valid, txn_count} !== {1'b0, 4'd2}) begin
      n_err++; $display("FAIL awdly_single_rsp: rsp_v=%b txn=%0d required 0/2", rsp_valid, txn_count);
    end
    slave_idle();
  endtask

  task automatic test_read_delay();
    logic rready_ok;
    bus.m_arready = 1'b1;
    issue(1'b0, 32'h0, 32'hFFFFFFFF, 4'hF);
    n_cmp++;
    if ({bus.m_arvalid, bus.m_rready, bus.m_araddr} !== {1'b1, 1'b0, 32'h0}) begin
      n_err++; $display("FAIL rd_t1: arvalid=%b rready=%b araddr=%h required 1/0/0", bus.m_arvalid, bus.m_rready, bus.m_araddr);
    end
    @(negedge clk);
    bus.m_arready = 1'b0;
    rready_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (bus.m_rready !== 1'b1 || rsp_valid !== 1'b0 || bus.m_arvalid !== 1'b0) rready_ok = 1'b0;
      if (i == 4) begin bus.m_rvalid = 1'b1; bus.m_rdata = 32'hC0000002; bus.m_rresp = 2'b00; end
      @(negedge clk);
    end
    n_cmp++;
    if (rready_ok !== 1'b1) begin n_err++; $display("FAIL rd_wait_rready: got %b required 1", rready_ok); end
    bus.m_rvalid = 1'b0;
    n_cmp++;
    if ({rsp_valid, rsp_write, rsp_resp, bus.m_rready, rsp_rdata} !== {1'b1, 1'b0, 2'b00, 1'b0, 32'hC0000002}) begin
      n_err++; $display("FAIL rd_rsp: v=%b w=%b resp=%b rready=%b rdata=%h required 1/0/00/0/c0000002",
        rsp_valid, rsp_write, rsp_resp, bus.m_rready, rsp_rdata);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_cmp++;
    if (txn_count !== 4'd3) begin n_err++; $display("FAIL rd_txn: got %0d required 3", txn_count); end
    slave_idle();
  endtask

  task automatic test_error();
    bus.m_awready = 1'b1; bus.m_wready = 1'b1; bus.m_bvalid = 1'b1; bus.m_bresp = 2'b10;
    issue(1'b1, 32'h30, 32'h1, 4'h1);
    @(negedge clk);
    @(negedge clk);
    bus.m_bvalid = 1'b0;
    n_cmp++;
    if ({rsp_valid, rsp_resp, err_sticky} !== 4'b1101) begin
      n_err++; $display("FAIL err_set: rsp_v,resp,err=%b required 1101", {rsp_valid, rsp_resp, err_sticky});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_cmp++;
    if (err_sticky !== 1'b0) begin n_err++; $display("FAIL err_clear: got %b required 0", err_sticky); end
    bus.m_bvalid = 1'b1; bus.m_bresp = 2'b10;
    issue(1'b1, 32'h34, 32'h2, 4'h2);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    bus.m_bvalid = 1'b0;
    n_cmp++;
    if ({err_sticky, rsp_resp} !== 3'b110) begin
      n_err++; $display("FAIL err_set_wins: err,resp=%b required 110", {err_sticky, rsp_resp});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_cmp++;
    if ({err_sticky, txn_count} !== {1'b0, 4'd5}) begin
      n_err++; $display("FAIL err_end: err=%b txn=%0d required 0/5", err_sticky, txn_count);
    end
    slave_idle();
  endtask

  task automatic test_rsp_backpressure();
    logic hold_ok;
    bus.m_arready = 1'b1; bus.m_rvalid = 1'b1; bus.m_rdata = 32'hA5A50001; bus.m_rresp = 2'b00;
    issue(1'b0, 32'h40, 32'h0, 4'h0);
    n_cmp++;
    if (bus.m_rready !== 1'b0) begin n_err++; $display("FAIL bp_r_pending: rready=%b required 0", bus.m_rready); end
    @(negedge clk);
    @(negedge clk);
    bus.m_rvalid = 1'b0; bus.m_rdata = 32'h0;
    hold_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || rsp_rdata !== 32'hA5A50001 || rsp_write !== 1'b0) hold_ok = 1'b0;
      if (i == 4) rsp_ready = 1'b1;
      else @(negedge clk);
    end
    n_cmp++;
    if (hold_ok !== 1'b1) begin n_err++; $display("FAIL bp_hold: got %b required 1", hold_ok); end
    @(negedge clk);
    rsp_ready = 1'b0;
    n_cmp++;
    if ({rsp_valid, cmd_ready, txn_count} !== {1'b0, 1'b1, 4'd6}) begin
      n_err++; $display("FAIL bp_release: rsp_v=%b cmd_rdy=%b txn=%0d required 0/1/6", rsp_valid, cmd_ready, txn_count);
    end
    slave_idle();
  endtask

  task automatic test_reset_mid();
    logic no_rsp;
    issue(1'b1, 32'h50, 32'h5, 4'hF);
    n_cmp++;
    if ({bus.m_awvalid, bus.m_wvalid} !== 2'b11) begin
      n_err++; $display("FAIL rstmid_pre: aw,w=%b required 11", {bus.m_awvalid, bus.m_wvalid});
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.m_awvalid, bus.m_wvalid, rsp_valid, cmd_ready, txn_count} !== 8'h00) begin
      n_err++; $display("FAIL rstmid_drop: aw,w,rsp,rdy,txn=%b required 0", {bus.m_awvalid, bus.m_wvalid, rsp_valid, cmd_ready, txn_count});
    end
    rst = 1'b0;
    bus.m_awready = 1'b1; bus.m_wready = 1'b1; bus.m_bvalid = 1'b1;
    no_rsp = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || bus.m_awvalid !== 1'b0 || cmd_ready !== 1'b1) no_rsp = 1'b0;
    end
    n_cmp++;
    if ({no_rsp, txn_count} !== {1'b1, 4'd0}) begin
      n_err++; $display("FAIL rstmid_after: quiet=%b txn=%0d required 1/0", no_rsp, txn_count);
    end
    slave_idle();
  endtask

  task automatic test_back_to_back_wrap();
    int t;
    bus.m_awready = 1'b1; bus.m_wready = 1'b1; bus.m_bvalid = 1'b1; bus.m_bresp = 2'b00;
    bus.m_arready = 1'b1; bus.m_rvalid = 1'b1; bus.m_rdata = 32'h77; bus.m_rresp = 2'b00;
    rsp_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      issue(k[0], 32'h100 + 32'(k), 32'(k), 4'hF);
      t = 0;
      while (!rsp_valid && t < 20) begin @(negedge clk); t++; end
      if (!rsp_valid) begin
        n_cmp++; n_err++;
        $display("FAIL wrap_rsp_timeout: txn %0d rsp_valid=%b required 1", k, rsp_valid);
      end
      @(negedge clk);
      if (k == 14) begin
        n_cmp++;
        if ({txn_count, cmd_ready} !== {4'd15, 1'b1}) begin
          n_err++; $display("FAIL wrap_pre: txn=%0d cmd_rdy=%b required 15/1", txn_count, cmd_ready);
        end
      end
    end
    rsp_ready = 1'b0;
    n_cmp++;
    if (txn_count !== 4'd0) begin n_err++; $display("FAIL wrap_zero: txn=%0d required 0", txn_count); end
    slave_idle();
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0; err_clr = 1'b0;
    slave_idle();
    @(negedge clk);
    test_reset();
    test_write_zero_wait();
    test_aw_delay();
    test_read_delay();
    test_error();
    test_rsp_backpressure();
    test_reset_mid();
    test_back_to_back_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time exceeded 200000 required completion");
    $fatal(1, "timeout");
  end

endmodule
